gpu_tex_cache: RTL and testbench

- Texture cache responder serving the pixel pipeline controller.
- Accepts a texel lookup at c0 and returns hit/miss plus a 16-bit texel at c1.
- On a miss, accepts the pipeline's line-fill request, fetches one 8-byte line (4 halfwords) from the VRAM arbiter in two 32-bit beats, then pulses completion so the paused pipeline can replay its lookup.
- Sits between GPUPipeCtrl2 and the memory arbiter.

---
 rtl/gpu_tex_pkg.sv | 38 +++
 rtl/gpu_tex_cache_ram.sv | 44 ++++
 rtl/gpu_tex_cache.sv | 191 +++++++++++++++++++
 tb/tb_gpu_tex_cache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_tex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_tex_pkg
//  Purpose  : Shared fill-state encoding, widths and address slice helpers
//             for the texture cache.
//  Revision : 1.0 - initial release
// ============================================================================
package gpu_tex_pkg;

    localparam int LINE_HW    = 4;
    localparam int ADR_W      = 19;
    localparam int LINE_ADR_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BEAT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_DONE  = 3'd4
    } fillState_t;

    // Callers truncate the result to their index width.
    function automatic logic [LINE_ADR_W-1:0] lineIndex(
        input logic [LINE_ADR_W-1:0] lineAdr,
        input int                    indexBits
    );
        return lineAdr & ((LINE_ADR_W'(1) << indexBits) - LINE_ADR_W'(1));
    endfunction

    function automatic logic [LINE_ADR_W-1:0] lineTag(
        input logic [LINE_ADR_W-1:0] lineAdr,
        input int                    indexBits
    );
        return lineAdr >> indexBits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_tex_cache_ram.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_tex_cache_ram
//  Purpose  : Simple dual-port line store, registered read, single write.
//  Revision : 1.0 - initial release
// ============================================================================
module gpu_tex_cache_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 64
) (
    input  logic                 clk,
    input  logic                 i_nrst,
    input  logic                 i_rdEn,
    input  logic [ADDR_BITS-1:0] i_rdAddr,
    output logic [DATA_BITS-1:0] o_rdData,
    input  logic                 i_wrEn,
    input  logic [ADDR_BITS-1:0] i_wrAddr,
    input  logic [DATA_BITS-1:0] i_wrData
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Only the output register is reset so the texel output starts at zero.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule
`default_nettype wire

// File: rtl/gpu_tex_cache.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_tex_cache
//  Purpose  : Direct-mapped texel cache with 1-cycle lookup and a two-beat
//             line-fill engine toward the VRAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module gpu_tex_cache
    import gpu_tex_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_invalidate,
    input  logic        requDataTex_c0,
    input  logic [18:0] adrTexReq_c0,
    output logic        TexHit_c1,
    output logic        TexMiss_c1,
    output logic [15:0] dataTex_c1,
    input  logic        requTexCacheUpdate_c1,
    input  logic [16:0] adrTexCacheUpdate_c0,
    output logic        updateTexCacheComplete,
    output logic        o_memReq,
    output logic [16:0] o_memAdr,
    input  logic        i_memAck,
    input  logic        i_memDataValid,
    input  logic [31:0] i_memData
);

    localparam int TAG_BITS  = LINE_ADR_W - INDEX_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int LINE_BITS = LINE_HW * 16;

    fillState_t r_state;
    fillState_t w_nextState;

    logic                  r_reqValid;
    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_BITS-1:0]   r_tag;
    logic [1:0]            r_hw;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tagArr [LINES];
    logic [LINE_ADR_W-1:0] r_memAdr;
    logic                  r_stale;
    logic [31:0]           r_beat0;

    logic [LINE_ADR_W-1:0] w_reqLine;
    logic [INDEX_BITS-1:0] w_reqIdx;
    logic [TAG_BITS-1:0]   w_reqTag;
    logic [INDEX_BITS-1:0] w_fillIdx;
    logic [TAG_BITS-1:0]   w_fillTag;
    logic                  w_fillWrite;
    logic                  w_fillBusy;
    logic                  w_hit;
    logic [LINE_BITS-1:0]  w_rdLine;

    assign w_reqLine = adrTexReq_c0[ADR_W-1:2];
    assign w_reqIdx  = INDEX_BITS'(lineIndex(w_reqLine, INDEX_BITS));
    assign w_reqTag  = TAG_BITS'(lineTag(w_reqLine, INDEX_BITS));
    assign w_fillIdx = INDEX_BITS'(lineIndex(r_memAdr, INDEX_BITS));
    assign w_fillTag = TAG_BITS'(lineTag(r_memAdr, INDEX_BITS));

    // ---------------- lookup pipeline ----------------
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_reqValid <= 1'b0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_hw       <= '0;
        end else begin
            r_reqValid <= requDataTex_c0;
            if (requDataTex_c0) begin
                r_idx <= w_reqIdx;
                r_tag <= w_reqTag;
                r_hw  <= adrTexReq_c0[1:0];
            end
        end
    end

    gpu_tex_cache_ram #(
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (LINE_BITS)
    ) u_ram (
        .clk      (clk),
        .i_nrst   (i_nrst),
        .i_rdEn   (requDataTex_c0),
        .i_rdAddr (w_reqIdx),
        .o_rdData (w_rdLine),
        .i_wrEn   (w_fillWrite),
        .i_wrAddr (w_fillIdx),
        .i_wrData ({i_memData, r_beat0})
    );

    // A line under fill never hits: the whole cache reports miss while busy.
    assign w_hit      = r_reqValid & r_valid[r_idx] & (r_tagArr[r_idx] == r_tag)
                      & (r_state == ST_IDLE);
    assign TexHit_c1  = w_hit;
    assign TexMiss_c1 = r_reqValid & ~w_hit;

    always_comb begin
        dataTex_c1 = w_rdLine[15:0];
        case (r_hw)
            2'd1:    dataTex_c1 = w_rdLine[31:16];
            2'd2:    dataTex_c1 = w_rdLine[47:32];
            2'd3:    dataTex_c1 = w_rdLine[63:48];
            default: ;
        endcase
    end

    // ---------------- fill FSM ----------------
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState            = r_state;
        o_memReq               = 1'b0;
        updateTexCacheComplete = 1'b0;
        w_fillWrite            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (requTexCacheUpdate_c1) w_nextState = ST_REQ;
            end
            ST_REQ: begin
                o_memReq = 1'b1;
                if (i_memAck) w_nextState = ST_BEAT0;
            end
            ST_BEAT0: begin
                if (i_memDataValid) w_nextState = ST_BEAT1;
            end
            ST_BEAT1: begin
                if (i_memDataValid) begin
                    w_fillWrite = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                updateTexCacheComplete = 1'b1;
                w_nextState            = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign w_fillBusy = (r_state == ST_REQ) | (r_state == ST_BEAT0) | (r_state == ST_BEAT1);

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_memAdr <= '0;
            r_stale  <= 1'b0;
            r_beat0  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && requTexCacheUpdate_c1) begin
                r_memAdr <= adrTexCacheUpdate_c0;
                r_stale  <= 1'b0;
            end else if (i_invalidate && w_fillBusy) begin
                r_stale  <= 1'b1;
            end
            if ((r_state == ST_BEAT0) && i_memDataValid) begin
                r_beat0 <= i_memData;
            end
        end
    end

    // Invalidate wins over a same-cycle fill write, leaving that line invalid.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_valid <= '0;
        end else if (i_invalidate) begin
            r_valid <= '0;
        end else if (w_fillWrite) begin
            r_valid[w_fillIdx] <= ~r_stale;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fillWrite) begin
            r_tagArr[w_fillIdx] <= w_fillTag;
        end
    end

    assign o_memAdr = r_memAdr;

endmodule
`default_nettype wire

// File: tb/tb_gpu_tex_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_tex_cache
//  Purpose  : Directed self-checking bench for gpu_tex_cache.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpu_tex_cache;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_invalidate;
    logic        requDataTex_c0;
    logic [18:0] adrTexReq_c0;
    logic        TexHit_c1;
    logic        TexMiss_c1;
    logic [15:0] dataTex_c1;
    logic        requTexCacheUpdate_c1;
    logic [16:0] adrTexCacheUpdate_c0;
    logic        updateTexCacheComplete;
    logic        o_memReq;
    logic [16:0] o_memAdr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;

    int vectors     = 0;
    int miscompares = 0;
    int memAcks     = 0;

    gpu_tex_cache #(.INDEX_BITS(8)) dut (
        .clk                    (clk),
        .i_nrst                 (i_nrst),
        .i_invalidate           (i_invalidate),
        .requDataTex_c0         (requDataTex_c0),
        .adrTexReq_c0           (adrTexReq_c0),
        .TexHit_c1              (TexHit_c1),
        .TexMiss_c1             (TexMiss_c1),
        .dataTex_c1             (dataTex_c1),
        .requTexCacheUpdate_c1  (requTexCacheUpdate_c1),
        .adrTexCacheUpdate_c0   (adrTexCacheUpdate_c0),
        .updateTexCacheComplete (updateTexCacheComplete),
        .o_memReq               (o_memReq),
        .o_memAdr               (o_memAdr),
        .i_memAck               (i_memAck),
        .i_memDataValid         (i_memDataValid),
        .i_memData              (i_memData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_memReq && i_memAck) memAcks++;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [18:0] adr,
                          input logic expHit, input logic [15:0] expData);
        requDataTex_c0 = 1'b1;
        adrTexReq_c0   = adr;
        step();
        requDataTex_c0 = 1'b0;
        checkVal({tag, ".hit"},  64'(TexHit_c1),  64'(expHit));
        checkVal({tag, ".miss"}, 64'(TexMiss_c1), 64'(!expHit));
        if (expHit) checkVal({tag, ".data"}, 64'(dataTex_c1), 64'(expData));
    endtask

    // invAt: 0 none, 1 invalidate on the BEAT0 edge, 2 on the BEAT1 write edge
    task automatic fill(input string tag, input logic [16:0] lineAdr,
                        input logic [31:0] b0, input logic [31:0] b1, input int invAt,
                        input logic [18:0] probeAdr, input logic [18:0] replayAdr,
                        input logic replayHit, input logic [15:0] replayData);
        int acks0;
        acks0 = memAcks;
        requTexCacheUpdate_c1 = 1'b1;
        adrTexCacheUpdate_c0  = lineAdr;
        step();
        checkVal({tag, ".memReq"}, 64'(o_memReq), 64'(1));
        checkVal({tag, ".memAdr"}, 64'(o_memAdr), 64'(lineAdr));
        lookup({tag, ".probe"}, probeAdr, 1'b0, 16'h0);
        checkVal({tag, ".reqHeld"}, 64'(o_memReq), 64'(1));
        i_memAck = 1'b1;
        step();
        i_memAck = 1'b0;
        checkVal({tag, ".reqDrop"}, 64'(o_memReq), 64'(0));
        i_memDataValid = 1'b1;
        i_memData      = b0;
        i_invalidate   = (invAt == 1);
        step();
        i_memData      = b1;
        i_invalidate   = (invAt == 2);
        step();
        i_invalidate   = 1'b0;
        i_memDataValid = 1'b0;
        checkVal({tag, ".cmpl"}, 64'(updateTexCacheComplete), 64'(1));
        // replay presented in DONE while the fill request is still held
        lookup({tag, ".replay"}, replayAdr, replayHit, replayData);
        checkVal({tag, ".cmplPulse"}, 64'(updateTexCacheComplete), 64'(0));
        requTexCacheUpdate_c1 = 1'b0;
        step();
        checkVal({tag, ".noRestart"}, 64'(o_memReq), 64'(0));
        checkVal({tag, ".oneReq"}, 64'(memAcks - acks0), 64'(1));
    endtask

    logic [15:0] streamExp [4];

    initial begin
        i_nrst = 1'b0;
        i_invalidate = 1'b0;
        requDataTex_c0 = 1'b0;
        adrTexReq_c0 = '0;
        requTexCacheUpdate_c1 = 1'b0;
        adrTexCacheUpdate_c0 = '0;
        i_memAck = 1'b0;
        i_memDataValid = 1'b0;
        i_memData = '0;
        streamExp[0] = 16'hAAAA;
        streamExp[1] = 16'hBBBB;
        streamExp[2] = 16'hCCCC;
        streamExp[3] = 16'hDDDD;
        step();
        step();
        checkVal("rst.hit",  64'(TexHit_c1), 64'(0));
        checkVal("rst.miss", 64'(TexMiss_c1), 64'(0));
        checkVal("rst.data", 64'(dataTex_c1), 64'(0));
        checkVal("rst.cmpl", 64'(updateTexCacheComplete), 64'(0));
        checkVal("rst.req",  64'(o_memReq), 64'(0));
        checkVal("rst.adr",  64'(o_memAdr), 64'(0));
        i_nrst = 1'b1;
        step();

        // cold miss and fill
        lookup("cold.look", 19'h00123, 1'b0, 16'h0);
        step();
        checkVal("idle.hit",  64'(TexHit_c1), 64'(0));
        checkVal("idle.miss", 64'(TexMiss_c1), 64'(0));
        fill("cold", 17'h00048, 32'hBBBBAAAA, 32'hDDDDCCCC, 0,
             19'h00123, 19'h00123, 1'b1, 16'hDDDD);

        // back-to-back hit stream
        for (int i = 0; i < 4; i++) begin
            requDataTex_c0 = 1'b1;
            adrTexReq_c0   = 19'h00120 + 19'(i);
            step();
            checkVal("stream.hit",  64'(TexHit_c1), 64'(1));
            checkVal("stream.data", 64'(dataTex_c1), 64'(streamExp[i]));
        end
        requDataTex_c0 = 1'b0;

        // conflict eviction; probe of a cached line during the fill must miss
        lookup("conf.look", 19'h40123, 1'b0, 16'h0);
        fill("evict", 17'h10048, 32'h22221111, 32'h44443333, 0,
             19'h00123, 19'h40123, 1'b1, 16'h4444);
        lookup("evict.old", 19'h00123, 1'b0, 16'h0);
        lookup("evict.new", 19'h40120, 1'b1, 16'h1111);

        // c1 lookup in the invalidate cycle sees pre-clear valid bits
        requDataTex_c0 = 1'b1;
        adrTexReq_c0   = 19'h40121;
        step();
        requDataTex_c0 = 1'b0;
        i_invalidate   = 1'b1;
        checkVal("preclr.hit",  64'(TexHit_c1), 64'(1));
        checkVal("preclr.data", 64'(dataTex_c1), 64'(16'h2222));
        step();
        i_invalidate = 1'b0;
        lookup("postclr", 19'h40121, 1'b0, 16'h0);

        // invalidate during BEAT0 leaves the filled line invalid
        fill("invB0", 17'h00048, 32'h66665555, 32'h88887777, 1,
             19'h00123, 19'h00123, 1'b0, 16'h0);
        fill("refill", 17'h00048, 32'h66665555, 32'h88887777, 0,
             19'h40123, 19'h00123, 1'b1, 16'h8888);
        lookup("refill.hw2", 19'h00122, 1'b1, 16'h7777);

        // invalidate on the BEAT1 write edge
        fill("invB1", 17'h10048, 32'h22221111, 32'h44443333, 2,
             19'h00120, 19'h40123, 1'b0, 16'h0);
        lookup("invB1.other", 19'h00123, 1'b0, 16'h0);

        // async reset during BEAT1
        fill("pre6", 17'h00048, 32'hBBBBAAAA, 32'hDDDDCCCC, 0,
             19'h00120, 19'h00121, 1'b1, 16'hBBBB);
        requTexCacheUpdate_c1 = 1'b1;
        adrTexCacheUpdate_c0  = 17'h00048;
        step();
        i_memAck = 1'b1;
        step();
        i_memAck = 1'b0;
        requTexCacheUpdate_c1 = 1'b0;
        i_memDataValid = 1'b1;
        i_memData      = 32'h12345678;
        step();
        i_memDataValid = 1'b0;
        lookup("b1.busy", 19'h00120, 1'b0, 16'h0);
        checkVal("b1.adr", 64'(o_memAdr), 64'(17'h00048));
        #2;
        i_nrst = 1'b0;
        #1;
        checkVal("arst.hit",  64'(TexHit_c1), 64'(0));
        checkVal("arst.miss", 64'(TexMiss_c1), 64'(0));
        checkVal("arst.data", 64'(dataTex_c1), 64'(0));
        checkVal("arst.cmpl", 64'(updateTexCacheComplete), 64'(0));
        checkVal("arst.req",  64'(o_memReq), 64'(0));
        checkVal("arst.adr",  64'(o_memAdr), 64'(0));
        i_memDataValid = 1'b1;
        i_memData      = 32'h9ABCDEF0;
        step();
        i_nrst = 1'b1;
        step();
        step();
        i_memDataValid = 1'b0;
        checkVal("late.cmpl", 64'(updateTexCacheComplete), 64'(0));
        checkVal("late.req",  64'(o_memReq), 64'(0));
        lookup("arst.old0", 19'h00120, 1'b0, 16'h0);
        lookup("arst.old3", 19'h00123, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
